// File: rtl/lt_cmp_scheduler.sv
// Round-robin scheduler feeding a 3-stage "folded square" less-than compare pipeline.
// Credit-gated issue into a small response FIFO; the pipeline itself never stalls.
module lt_cmp_scheduler #(
    parameter int  NUM_REQ    = 4,
    parameter int  BITWIDTH   = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_result,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = 4;
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    typedef struct packed {
        logic            result;
        logic [ID_W-1:0] id;
    } rsp_t;

    logic [ID_W-1:0]       ptr;
    logic                  rst_q;
    logic                  s1_v, s2_v, s3_v;
    logic [ID_W-1:0]       s1_id, s2_id, s3_id;
    logic [BITWIDTH-1:0]   s1_a, s1_b;
    logic [2*BITWIDTH-1:0] s2_sq_a, s2_sq_b;
    logic [BITWIDTH-1:0]   s3_fold_a, s3_fold_b;

    rsp_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W:0]         rr_sum;
    logic                  accept;
    logic [ID_W-1:0]       next_ptr;
    logic [BITWIDTH-1:0]   sel_a, sel_b;
    logic [2*BITWIDTH-1:0] sq_a, sq_b;
    logic [BITWIDTH-1:0]   fold_a, fold_b;
    logic [OCC_W-1:0]      occupancy;
    logic                  credit_ok;
    logic                  push, pop;
    rsp_t                  head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every result ever issued is either in a pipeline stage or in the FIFO.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_v) + OCC_W'(s2_v) + OCC_W'(s3_v);
    assign push      = s3_v;
    assign pop       = rsp_valid && rsp_ready;
    // A pop this cycle frees its slot in time for the new issue to land behind it.
    assign credit_ok = (occupancy - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        rr_sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (rr_sum >= NUM_REQ_W) rr_sum = rr_sum - NUM_REQ_W;
            if (!grant_found && req_valid[rr_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = rr_sum[ID_W-1:0];
            end
        end
    end

    // Issue is also held off for the first cycle out of reset.
    assign req_ready = (grant_found && credit_ok && !rst && !rst_q)
                       ? (NUM_REQ'(1) << grant_id) : '0;
    assign accept    = |req_ready;
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*BITWIDTH +: BITWIDTH];
                sel_b = req_b[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    assign sq_a   = {{BITWIDTH{1'b0}}, s1_a} * {{BITWIDTH{1'b0}}, s1_a};
    assign sq_b   = {{BITWIDTH{1'b0}}, s1_b} * {{BITWIDTH{1'b0}}, s1_b};
    assign fold_a = s2_sq_a[BITWIDTH-1:0] ^ s2_sq_a[2*BITWIDTH-1:BITWIDTH];
    assign fold_b = s2_sq_b[BITWIDTH-1:0] ^ s2_sq_b[2*BITWIDTH-1:BITWIDTH];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) ptr <= next_ptr;
            s1_v <= accept;
            s2_v <= s1_v;
            s3_v <= s2_v;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // NOTE: datapath registers and FIFO storage are not reset; the valid bits and
    // FIFO count qualify them, so stale contents are never observed.
    always_ff @(posedge clk) begin
        s1_id     <= grant_id;
        s1_a      <= sel_a;
        s1_b      <= sel_b;
        s2_id     <= s1_id;
        s2_sq_a   <= sq_a;
        s2_sq_b   <= sq_b;
        s3_id     <= s2_id;
        s3_fold_a <= fold_a;
        s3_fold_b <= fold_b;
        if (push) mem[wr_ptr] <= '{result: (s3_fold_a < s3_fold_b), id: s3_id};
    end

    assign head       = mem[rd_ptr];
    assign rsp_valid  = !rst && (fifo_count != '0);
    assign rsp_result = rsp_valid ? head.result : 1'b0;
    assign rsp_id     = rsp_valid ? head.id : '0;
    assign idle       = rst || (occupancy == '0);

endmodule

// File: tb/tb_lt_cmp_scheduler.sv
// Self-checking bench for lt_cmp_scheduler: a transaction-level model (queue of
// outstanding results with due cycles) checked every cycle, plus directed literal checks.
module tb_lt_cmp_scheduler;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_result;
    logic [1:0]     rsp_id;
    logic           idle;

    lt_cmp_scheduler #(.NUM_REQ(N), .BITWIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [W-1:0] x);
        longint sq;
        sq = longint'(x) * longint'(x);
        return W'(sq) ^ W'(sq >> W);
    endfunction

    // Model: every accepted request is an outstanding item that becomes visible
    // four cycles after its accept and leaves in accept order when consumed.
    typedef struct {
        logic res;
        int   id;
        int   due;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    mptr = 0;
    bit    post_rst = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        logic         pop;
        bit           found;
        int           g;
        int           idx;
        item_t        it;
        if (rst) begin
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_idle", 32'(idle), 1);
            check("rst_rsp_result", 32'(rsp_result), 0);
            check("rst_rsp_id", 32'(rsp_id), 0);
            q.delete();
            mptr     = 0;
            post_rst = 1'b1;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].due <= cyc);
            pop       = exp_valid && rsp_ready;
            found     = 1'b0;
            g         = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            exp_ready = '0;
            if (found && !post_rst && (q.size() - int'(pop)) < D) exp_ready[g] = 1'b1;

            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check("idle", 32'(idle), 32'(q.size() == 0));
            if (exp_valid) begin
                check("rsp_result", 32'(rsp_result), 32'(q[0].res));
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            end
            if (post_rst) begin
                check("post_rst_result", 32'(rsp_result), 0);
                check("post_rst_id", 32'(rsp_id), 0);
            end

            if (pop) void'(q.pop_front());
            if (exp_ready != '0) begin
                it.res = fold(req_a[g*W +: W]) < fold(req_b[g*W +: W]);
                it.id  = g;
                it.due = cyc + 4;
                q.push_back(it);
                mptr = (g + 1) % N;
            end
            post_rst = 1'b0;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    int          got;
    int          acc;
    int          first_c;
    int          last_c;
    logic [31:0] ids [0:7];
    logic [31:0] res [0:7];
    logic [N-1:0] grants [0:7];

    initial begin
        // Pin the model's fold against hand-computed values.
        check("fold_3", 32'(fold(16'd3)), 9);
        check("fold_5", 32'(fold(16'd5)), 25);
        check("fold_0100", 32'(fold(16'h0100)), 1);
        check("fold_0001", 32'(fold(16'h0001)), 1);
        check("fold_ffff", 32'(fold(16'hFFFF)), 32'hFFFF);
        check("fold_0000", 32'(fold(16'h0000)), 0);

        set_ops(0, 16'd3, 16'd5);
        set_ops(1, 16'h0100, 16'h0001);
        set_ops(2, 16'hFFFF, 16'h0000);
        set_ops(3, 16'h0000, 16'hFFFF);

        rst = 1'b1;
        step();
        step();

        // Single request from req0; nothing is granted in the first cycle out of reset.
        rst = 1'b0;
        req_valid = 4'b0001;
        sample();
        check("t1_post_rst_ready", 32'(req_ready), 0);
        check("t1_post_rst_idle", 32'(idle), 1);
        step();
        sample();
        check("t1_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        step();
        step();
        sample();
        check("t1_rsp_valid_T4", 32'(rsp_valid), 1);
        check("t1_rsp_result", 32'(rsp_result), 1);
        check("t1_rsp_id", 32'(rsp_id), 0);
        step();
        sample();
        check("t1_idle_T5", 32'(idle), 1);
        check("t1_rsp_valid_T5", 32'(rsp_valid), 0);
        step();

        // Fold boundary operands from requesters 1..3, one per cycle.
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (rsp_valid) begin
                if (got < 8) begin
                    ids[got] = 32'(rsp_id);
                    res[got] = 32'(rsp_result);
                end
                got++;
            end
            step();
        end
        check("t2_count", 32'(got), 3);
        check("t2_id0", ids[0], 1);
        check("t2_res0", res[0], 0);
        check("t2_id1", ids[1], 2);
        check("t2_res1", res[1], 0);
        check("t2_id2", ids[2], 3);
        check("t2_res2", res[2], 1);

        // All requesters valid for 8 cycles: grants rotate 0..3, one response per cycle.
        got = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            sample();
            if (c < 8) grants[c] = req_ready;
            if (rsp_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                if (got < 8) ids[got] = 32'(rsp_id);
                got++;
            end
            step();
        end
        for (int i = 0; i < 8; i++) check("t3_grant", 32'(grants[i]), 32'(1) << (i % 4));
        check("t3_rsp_count", 32'(got), 8);
        check("t3_first_rsp_cycle", 32'(first_c), 4);
        check("t3_last_rsp_cycle", 32'(last_c), 11);
        for (int i = 0; i < 8; i++) check("t3_rsp_id", ids[i], 32'(i % 4));

        // Consumer stalled: exactly FIFO_DEPTH accepts, then no more grants.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (req_ready != '0) acc++;
            step();
        end
        sample();
        check("t4_accepts_stalled", 32'(acc), 4);
        check("t4_ready_blocked", 32'(req_ready), 0);
        check("t4_rsp_held_id", 32'(rsp_id), 0);
        step();

        // Release the consumer: queued responses drain in order and issue resumes.
        rsp_ready = 1'b1;
        acc = 0;
        got = 0;
        for (int c = 0; c < 28; c++) begin
            req_valid = (c < 16) ? 4'b1111 : 4'b0000;
            sample();
            if (req_ready != '0) acc++;
            if (rsp_valid) begin
                if (got < 8) begin
                    ids[got] = 32'(rsp_id);
                    res[got] = 32'(rsp_result);
                end
                got++;
            end
            step();
        end
        check("t4_accepts_resumed", 32'(acc), 16);
        check("t4_rsp_total", 32'(got), 20);
        check("t4_id0", ids[0], 0);
        check("t4_id1", ids[1], 1);
        check("t4_id2", ids[2], 2);
        check("t4_id3", ids[3], 3);
        check("t4_res0", res[0], 1);
        check("t4_res3", res[3], 1);
        sample();
        check("t4_idle", 32'(idle), 1);
        step();

        // Reset mid-operation discards everything and returns the pointer to req0.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        step();
        req_valid = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            check("t5_no_stale_rsp", 32'(rsp_valid), 0);
            check("t5_idle", 32'(idle), 1);
            step();
        end
        req_valid = 4'b1111;
        sample();
        check("t5_first_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        for (int c = 0; c < 8; c++) step();
        sample();
        check("t5_final_idle", 32'(idle), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lt_cmp_scheduler.md
LT_CMP_SCHEDULER -- requirements
Module: lt_cmp_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter BITWIDTH, default 16, giving the operand width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the response FIFO entries (range 1..8).
REQ-004 The block SHALL have local ID_W = clog2(NUM_REQ).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester request valid.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester grant/accept.
REQ-009 The block SHALL have port req_a, input, NUM_REQ*BITWIDTH bits: operand a, requester i at slice [i*BITWIDTH +: BITWIDTH].
REQ-010 The block SHALL have port req_b, input, NUM_REQ*BITWIDTH bits: operand b, packed like req_a.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts response.
REQ-013 The block SHALL have port rsp_result, output, 1 bit: comparison result.
REQ-014 The block SHALL have port rsp_id, output, ID_W bits: index of the requester that issued the response.
REQ-015 The block SHALL have port idle, output, 1 bit: high when no operation is in flight and the FIFO is empty.

Function
REQ-016 The block SHALL compute fold(x) = sq[BITWIDTH-1:0] XOR sq[2*BITWIDTH-1:BITWIDTH], with sq = x*x unsigned at 2*BITWIDTH bits, and result = (fold(a) < fold(b)) unsigned.
REQ-017 Accept SHALL occur for requester i in a cycle where req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-018 Arbitration SHALL be round-robin with priority pointer ptr: grant the first valid requester at or after ptr, searching modulo NUM_REQ.
REQ-019 After an accept from requester i, ptr SHALL become (i+1) mod NUM_REQ; without an accept, ptr SHALL hold.
REQ-020 req_ready SHALL be combinational from req_valid, ptr and credit, and SHALL be all zero when credit = 0 or rst = 1.
REQ-021 credit SHALL equal FIFO_DEPTH - fifo_count - inflight, where inflight counts occupied pipeline stages (0..3).
REQ-022 An issue SHALL be permitted only when credit > 0, so the FIFO never overflows.
REQ-023 The pipeline SHALL have three registered stages, each with a valid bit and carrying the requester ID: S1 registers operands, S2 registers the two squares, S3 registers the two folds.
REQ-024 The compare on S3 SHALL be written into the FIFO at the end of S3's cycle.
REQ-025 Latency: an accept in cycle T SHALL give rsp_valid = 1 in cycle T+4 when the FIFO is empty.
REQ-026 The pipeline SHALL never stall; credit gating alone SHALL prevent loss.
REQ-027 The FIFO SHALL pop when rsp_valid and rsp_ready are both high; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-028 Responses SHALL leave in accept order; rsp_result and rsp_id SHALL hold stable while rsp_valid = 1 and rsp_ready = 0.
REQ-029 With FIFO_DEPTH >= 4 and rsp_ready held high, the block SHALL sustain one accept per cycle.
REQ-030 With FIFO_DEPTH < 4, throughput SHALL be limited by credit, with no loss.
REQ-031 req_valid dropping without an accept SHALL be legal and SHALL have no side effect.

Reset
REQ-032 While rst = 1 at a clock edge, the block SHALL clear: ptr = 0, all stage valids = 0, fifo_count = 0, FIFO pointers = 0.
REQ-033 During reset and in the cycle after it, the block SHALL drive rsp_valid = 0, req_ready = 0, idle = 1, rsp_result = 0 and rsp_id = 0.
REQ-034 Reset asserted mid-operation SHALL silently discard all in-flight and queued results; no response SHALL appear after reset for pre-reset requests.

Verification
REQ-035 Single request, req0 a=3 b=5, accepted at T, rsp_ready = 1 -> folds 9 and 25, rsp_valid at T+4, result = 1, id = 0, idle = 1 at T+5.
REQ-036 Fold boundary checks -> a=0x0100 b=0x0001 gives folds 1 and 1, result 0; a=0xFFFF b=0 gives folds 0xFFFF and 0, result 0; swapped operands give result 1.
REQ-037 All four requesters valid continuously with rsp_ready = 1 -> grants in order 0,1,2,3,0,... one per cycle, responses at 1 per cycle, ids in the same order.
REQ-038 rsp_ready = 0 with continuous requests, FIFO_DEPTH = 4 -> exactly 4 accepts, then req_ready = 0.
REQ-039 In the REQ-038 scenario, raising rsp_ready -> 4 responses in order, then accepts resume with no loss or duplication.
REQ-040 rst pulsed 2 cycles after 3 accepts -> no rsp_valid afterward, ptr = 0, the next accept goes to req0 when all requesters are valid.
